adc_conv_sequencer: RTL and testbench
=====================================

// Module: adc_conv_sequencer
// PURPOSE
//  Downstream/control companion of the ADC top: issues start_conversion pulses (single-shot or periodic),
//  syncs the self-timed conversion_finished flag into clk, captures the 16-bit result into a small FIFO
//  and offers it to the host on a valid/ready port. Flags overflow (FIFO full) and timeout (no finish).
// PARAMETERS
//  FIFO_DEPTH      4     result FIFO entries, power of 2, >=2
//  START_CYCLES    4     width of start_conversion_out pulse in clk cycles, >=1
//  TIMEOUT_CYCLES  4096  max clk cycles in WAIT_DONE before abort, >=16
// PORTS
//  clk                    in   1   system clock, all logic on rising edge
//  rst                    in   1   asynchronous reset, active-high
//  enable_in              in   1   1 = continuous periodic conversions
//  single_shot_in         in   1   1-cycle pulse: one conversion, honoured only in IDLE with enable_in=0
//  period_in              in   16  clk cycles between start rising edges in continuous mode
//  clear_flags_in         in   1   1-cycle pulse: clear overflow_out and timeout_out
//  start_conversion_out   out  1   start request to ADC top (registered)
//  conversion_finished_in in   1   ADC done flag, asynchronous to clk; result_in stable while high
//  result_in              in   16  ADC result
//  data_out               out  16  FIFO head; 16'h0000 when empty
//  data_valid_out         out  1   FIFO non-empty
//  data_ready_in          in   1   host accept; pop when valid & ready
//  fifo_level_out         out  $clog2(FIFO_DEPTH+1)  entries held, 0..FIFO_DEPTH
//  busy_out               out  1   FSM not in IDLE
//  overflow_out           out  1   sticky: result dropped because FIFO full
//  timeout_out            out  1   sticky: conversion aborted after TIMEOUT_CYCLES
// BEHAVIOUR
//  Reset (async, immediate): all outputs 0, FSM=IDLE, FIFO empty, sync flops 0, counters 0.
//  Sync: conversion_finished_in -> 2 flops (s1,s2) + s3; done_edge = s2 & ~s3. Only rising edges count;
//   a flag already high when WAIT_DONE is entered is ignored until it falls and rises again.
//  FSM: IDLE -> START when enable_in=1, or single_shot_in=1 with enable_in=0.
//   START: start_conversion_out=1 for exactly START_CYCLES cycles; period_cnt:=0 on the first one,
//     then +1 per cycle, saturating at 16'hFFFF. -> WAIT_DONE.
//   WAIT_DONE: on done_edge push result_in (sampled same edge) -> HOLDOFF.
//     tmo_cnt reaching TIMEOUT_CYCLES with no done_edge: set timeout_out, no push -> HOLDOFF.
//   HOLDOFF: enable_in=0 -> IDLE. Else -> START once period_cnt >= period_in-1, so rise-to-rise
//     spacing = max(period_in, START_CYCLES+conversion+2) cycles; period_in 0 or 1 = back-to-back
//     (one HOLDOFF cycle).
//  Latency: conversion_finished_in rising before edge k -> data_valid_out=1 after edge k+2.
//  enable_in dropped mid-conversion: current START/WAIT_DONE completes and its result is pushed;
//   no new start.
//  FIFO: push when full and no pop in same cycle -> drop, set overflow_out. Full with simultaneous
//   push+pop -> both happen, level unchanged, no overflow. Empty with pop -> ignored. Pointers wrap
//   mod FIFO_DEPTH. data_out combinational from head register.
//  Flags: clear_flags_in clears both sticky flags; a set event in the same cycle wins (flag stays 1).
//  single_shot_in outside IDLE, or with enable_in=1: ignored.
// TESTING
//  T1 single_shot=1, finished rises 20 cycles after start fall, result=16'hA5C3 -> start high 4
//     cycles; data_valid=1, data_out=16'hA5C3 3 edges after finished rise; busy=0 after; level=1.
//  T2 enable=1, period=100, ready=1, finish 30 cycles after each start -> start rises every 100
//     cycles exactly, 5 results in order, level never >1.
//  T3 enable=1, period=0, ready=0, 6 conversions (results 1..6) -> level=4, data_out=1, overflow=1,
//     results 5,6 dropped; then pop 4 -> 1,2,3,4 in order.
//  T4 FIFO full, push and pop same cycle -> level stays 4, overflow stays 0; clear_flags with
//     simultaneous drop -> overflow remains 1.
//  T5 finished held 0 -> timeout=1 after 4096 WAIT_DONE cycles, no push; finished held 1 entering
//     WAIT_DONE -> no capture until it falls and rises.
//  T6 rst=1 mid-WAIT_DONE with start high / FIFO level 3 -> all outputs 0 immediately, level 0,
//     IDLE after release.

Source files
------------

// File: rtl/adc_conv_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : adc_conv_sequencer                                                |
// | Purpose: Control companion of the ADC top. Issues start_conversion pulses  |
// |          (single-shot or periodic), synchronises the self-timed            |
// |          conversion_finished flag into clk, captures each 16-bit result    |
// |          into a small FIFO and offers it to the host on valid/ready.       |
// |          Sticky flags report dropped results (overflow) and conversions    |
// |          that never finished (timeout).                                    |
// | Ports  : clk, rst (async, active-high)                                     |
// |          enable_in, single_shot_in, period_in[15:0], clear_flags_in        |
// |          start_conversion_out            -> ADC top                        |
// |          conversion_finished_in, result_in[15:0]  <- ADC top (async flag)  |
// |          data_out[15:0], data_valid_out, data_ready_in  host stream        |
// |          fifo_level_out, busy_out, overflow_out, timeout_out  status       |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module adc_conv_sequencer #(
   parameter int FIFO_DEPTH     = 4,
   parameter int START_CYCLES   = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              enable_in,
   input  logic                              single_shot_in,
   input  logic [15:0]                       period_in,
   input  logic                              clear_flags_in,
   output logic                              start_conversion_out,
   input  logic                              conversion_finished_in,
   input  logic [15:0]                       result_in,
   output logic [15:0]                       data_out,
   output logic                              data_valid_out,
   input  logic                              data_ready_in,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level_out,
   output logic                              busy_out,
   output logic                              overflow_out,
   output logic                              timeout_out
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int LW = $clog2(FIFO_DEPTH + 1);
   localparam int SW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES);

   localparam logic [SW-1:0] START_LAST = SW'(START_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [LW-1:0] FULL_LVL   = LW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_START     = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_HOLDOFF   = 2'd3
   } state_t;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_t          state_q,      state_d;
   logic [SW-1:0]   start_cnt_q,  start_cnt_d;
   logic [TW-1:0]   tmo_cnt_q,    tmo_cnt_d;
   logic [15:0]     period_cnt_q, period_cnt_d;
   logic            start_q,      start_d;
   logic            s1_q, s2_q, s3_q;
   logic            s1_d, s2_d, s3_d;
   logic            overflow_q,   overflow_d;
   logic            timeout_q,    timeout_d;

   logic [15:0]     mem_q [FIFO_DEPTH];
   logic [15:0]     mem_d [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_q,     wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q,     rd_ptr_d;
   logic [LW-1:0]   level_q,      level_d;

   logic            done_edge;
   logic            period_reached;
   logic            push_req;
   logic            tmo_evt;
   logic            pop;
   logic            full;
   logic            do_push;
   logic            drop;

   // ---------------------------------------------------------------------
   // Finished-flag synchroniser; s3 only serves the rising-edge detector,
   // so a flag that is already high when WAIT_DONE starts never counts.
   // ---------------------------------------------------------------------
   always_comb begin
      s1_d = conversion_finished_in;
      s2_d = s1_q;
      s3_d = s2_q;
   end

   assign done_edge = s2_q & ~s3_q;

   // Compare period_cnt+1 against period_in in 17 bits so that period_in
   // of 0 or 1 simply means "restart immediately" without wrap-around.
   assign period_reached = ({1'b0, period_cnt_q} + 17'd1) >= {1'b0, period_in};

   // ---------------------------------------------------------------------
   // Sequencer next-state
   // ---------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      start_cnt_d  = start_cnt_q;
      tmo_cnt_d    = tmo_cnt_q;
      period_cnt_d = (period_cnt_q == 16'hFFFF) ? period_cnt_q : period_cnt_q + 16'd1;
      push_req     = 1'b0;
      tmo_evt      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // single_shot_in with enable_in high is covered by enable_in.
            if (enable_in || single_shot_in) begin
               state_d      = ST_START;
               start_cnt_d  = '0;
               period_cnt_d = '0;
            end
         end
         ST_START: begin
            if (start_cnt_q == START_LAST) begin
               state_d   = ST_WAIT_DONE;
               tmo_cnt_d = '0;
            end else begin
               start_cnt_d = start_cnt_q + SW'(1);
            end
         end
         ST_WAIT_DONE: begin
            if (done_edge) begin
               push_req = 1'b1;
               state_d  = ST_HOLDOFF;
            end else if (tmo_cnt_q == TMO_LAST) begin
               tmo_evt = 1'b1;
               state_d = ST_HOLDOFF;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
         end
         ST_HOLDOFF: begin
            if (!enable_in) begin
               state_d = ST_IDLE;
            end else if (period_reached) begin
               state_d      = ST_START;
               start_cnt_d  = '0;
               period_cnt_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Registered start output tracks the START state exactly.
      start_d = (state_d == ST_START);
   end

   // ---------------------------------------------------------------------
   // Result FIFO and sticky flags
   // ---------------------------------------------------------------------
   always_comb begin
      pop     = (level_q != '0) & data_ready_in;
      full    = (level_q == FULL_LVL);
      // A pop in the same cycle frees the slot the push needs.
      do_push = push_req & (~full | pop);
      drop    = push_req & full & ~pop;

      mem_d = mem_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = result_in;
      end

      wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop     ? rd_ptr_q + PW'(1) : rd_ptr_q;

      case ({do_push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      // A set event outranks a clear in the same cycle.
      overflow_d = drop    | (overflow_q & ~clear_flags_in);
      timeout_d  = tmo_evt | (timeout_q  & ~clear_flags_in);
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         start_cnt_q  <= '0;
         tmo_cnt_q    <= '0;
         period_cnt_q <= '0;
         start_q      <= 1'b0;
         s1_q         <= 1'b0;
         s2_q         <= 1'b0;
         s3_q         <= 1'b0;
         overflow_q   <= 1'b0;
         timeout_q    <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         start_cnt_q  <= start_cnt_d;
         tmo_cnt_q    <= tmo_cnt_d;
         period_cnt_q <= period_cnt_d;
         start_q      <= start_d;
         s1_q         <= s1_d;
         s2_q         <= s2_d;
         s3_q         <= s3_d;
         overflow_q   <= overflow_d;
         timeout_q    <= timeout_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         mem_q        <= mem_d;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign start_conversion_out = start_q;
   assign data_valid_out       = (level_q != '0);
   assign data_out             = (level_q != '0) ? mem_q[rd_ptr_q] : 16'h0000;
   assign fifo_level_out       = level_q;
   assign busy_out             = (state_q != ST_IDLE);
   assign overflow_out         = overflow_q;
   assign timeout_out          = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_conv_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_adc_conv_sequencer                                             |
// | Purpose: Directed self-checking bench for adc_conv_sequencer with a small  |
// |          behavioural ADC that answers each start pulse after a delay.      |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_adc_conv_sequencer;

   logic        clk;
   logic        rst = 1'b1;
   logic        enable_in = 1'b0;
   logic        single_shot_in = 1'b0;
   logic [15:0] period_in = 16'd0;
   logic        clear_flags_in = 1'b0;
   logic        start_conversion_out;
   logic        conversion_finished_in;
   logic [15:0] result_in;
   logic [15:0] data_out;
   logic        data_valid_out;
   logic        data_ready_in = 1'b0;
   logic [2:0]  fifo_level_out;
   logic        busy_out;
   logic        overflow_out;
   logic        timeout_out;

   // ADC stimulus: either the automatic model or direct drive from the main flow
   logic        adc_auto  = 1'b0;
   int          adc_delay = 5;
   logic [15:0] adc_base  = 16'd0;
   int          n_conv    = 0;
   logic        m_fin = 1'b0;
   logic [15:0] m_res = 16'd0;
   logic        d_fin = 1'b0;
   logic [15:0] d_res = 16'd0;

   assign conversion_finished_in = adc_auto ? m_fin : d_fin;
   assign result_in              = adc_auto ? m_res : d_res;

   int n_cmp = 0;
   int n_bad = 0;

   adc_conv_sequencer #(
      .FIFO_DEPTH     (4),
      .START_CYCLES   (4),
      .TIMEOUT_CYCLES (4096)
   ) dut (
      .clk                    (clk),
      .rst                    (rst),
      .enable_in              (enable_in),
      .single_shot_in         (single_shot_in),
      .period_in              (period_in),
      .clear_flags_in         (clear_flags_in),
      .start_conversion_out   (start_conversion_out),
      .conversion_finished_in (conversion_finished_in),
      .result_in              (result_in),
      .data_out               (data_out),
      .data_valid_out         (data_valid_out),
      .data_ready_in          (data_ready_in),
      .fifo_level_out         (fifo_level_out),
      .busy_out               (busy_out),
      .overflow_out           (overflow_out),
      .timeout_out            (timeout_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   // Automatic ADC: after start falls, wait adc_delay cycles, raise finished
   // with the next result for 3 cycles.
   initial begin
      logic prev;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (adc_auto && prev && !start_conversion_out) begin
            repeat (adc_delay) @(negedge clk);
            m_res  = adc_base + 16'(n_conv);
            n_conv = n_conv + 1;
            m_fin  = 1'b1;
            repeat (3) @(negedge clk);
            m_fin  = 1'b0;
         end
         prev = start_conversion_out;
      end
   end

   initial begin
      int          hi;
      int          c0;
      int          maxlvl;
      logic        prev_s;
      logic        found;
      int          rises[$];
      logic [15:0] got[$];
      logic [15:0] exp4 [4];

      // ---------------- reset state
      step(2);
      check_val("rst_start", start_conversion_out, 0);
      check_val("rst_valid", data_valid_out, 0);
      check_val("rst_level", fifo_level_out, 0);
      check_val("rst_busy",  busy_out, 0);
      check_val("rst_ovf",   overflow_out, 0);
      check_val("rst_tmo",   timeout_out, 0);
      check_val("rst_data",  data_out, 0);
      rst = 1'b0;
      step(2);

      // ---------------- T1 single shot
      single_shot_in = 1'b1;
      step;
      single_shot_in = 1'b0;
      check_val("t1_busy", busy_out, 1);
      hi = start_conversion_out ? 1 : 0;
      for (int i = 0; i < 6; i++) begin
         step;
         if (start_conversion_out) hi++;
      end
      check_val("t1_start_len", hi, 4);
      step(18);
      d_res = 16'hA5C3;
      d_fin = 1'b1;
      step(2);
      check_val("t1_valid_early", data_valid_out, 0);
      step;
      check_val("t1_valid", data_valid_out, 1);
      check_val("t1_data",  data_out, 16'hA5C3);
      check_val("t1_level", fifo_level_out, 1);
      step;
      check_val("t1_idle", busy_out, 0);
      d_fin = 1'b0;
      data_ready_in = 1'b1;
      step;
      data_ready_in = 1'b0;
      check_val("t1_pop_level", fifo_level_out, 0);
      check_val("t1_pop_data",  data_out, 0);

      // ---------------- T2 periodic, period 100
      adc_auto  = 1'b1;
      adc_delay = 30;
      adc_base  = 16'h1000 - 16'(n_conv);
      period_in = 16'd100;
      data_ready_in = 1'b1;
      enable_in = 1'b1;
      maxlvl = 0;
      prev_s = 1'b0;
      for (int c = 0; c < 480; c++) begin
         step;
         if (start_conversion_out && !prev_s) rises.push_back(c);
         prev_s = start_conversion_out;
         if (data_valid_out) got.push_back(data_out);
         if (int'(fifo_level_out) > maxlvl) maxlvl = int'(fifo_level_out);
      end
      enable_in = 1'b0;
      check_val("t2_rises", rises.size(), 5);
      for (int i = 1; i < rises.size(); i++) check_val("t2_spacing", rises[i] - rises[i-1], 100);
      check_val("t2_nres", got.size(), 5);
      for (int i = 0; i < got.size() && i < 5; i++) check_val("t2_res", got[i], 16'h1000 + 16'(i));
      check_val("t2_maxlvl", maxlvl, 1);
      step(3);
      check_val("t2_idle", busy_out, 0);
      data_ready_in = 1'b0;

      // ---------------- T3 back-to-back into a stalled FIFO
      adc_delay = 5;
      adc_base  = 16'd1 - 16'(n_conv);
      c0 = n_conv;
      period_in = 16'd0;
      enable_in = 1'b1;
      for (int c = 0; c < 400 && n_conv < c0 + 6; c++) step;
      enable_in = 1'b0;
      step(20);
      check_val("t3_level", fifo_level_out, 4);
      check_val("t3_head",  data_out, 1);
      check_val("t3_ovf",   overflow_out, 1);
      check_val("t3_idle",  busy_out, 0);
      data_ready_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_val("t3_pop", data_out, 16'(i + 1));
         step;
      end
      data_ready_in = 1'b0;
      check_val("t3_empty", data_valid_out, 0);
      clear_flags_in = 1'b1;
      step;
      clear_flags_in = 1'b0;
      check_val("t3_clear", overflow_out, 0);

      // ---------------- T4 full FIFO: push+pop, clear vs drop
      adc_base = 16'h0010 - 16'(n_conv);
      c0 = n_conv;
      enable_in = 1'b1;
      for (int c = 0; c < 400 && n_conv < c0 + 4; c++) step;
      enable_in = 1'b0;
      step(20);
      check_val("t4_full", fifo_level_out, 4);
      adc_auto = 1'b0;
      single_shot_in = 1'b1;
      step;
      single_shot_in = 1'b0;
      step(8);
      d_res = 16'hBEEF;
      d_fin = 1'b1;
      step(2);
      data_ready_in = 1'b1;
      step;
      data_ready_in = 1'b0;
      check_val("t4_pp_level", fifo_level_out, 4);
      check_val("t4_pp_ovf",   overflow_out, 0);
      check_val("t4_pp_head",  data_out, 16'h0011);
      step(3);
      d_fin = 1'b0;
      step(3);
      check_val("t4_idle", busy_out, 0);
      single_shot_in = 1'b1;
      step;
      single_shot_in = 1'b0;
      step(8);
      d_res = 16'hDEAD;
      d_fin = 1'b1;
      step(2);
      clear_flags_in = 1'b1;
      step;
      clear_flags_in = 1'b0;
      check_val("t4_drop_ovf",   overflow_out, 1);
      check_val("t4_drop_level", fifo_level_out, 4);
      step(3);
      d_fin = 1'b0;
      clear_flags_in = 1'b1;
      step;
      clear_flags_in = 1'b0;
      check_val("t4_clear", overflow_out, 0);
      exp4[0] = 16'h0011;
      exp4[1] = 16'h0012;
      exp4[2] = 16'h0013;
      exp4[3] = 16'hBEEF;
      data_ready_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_val("t4_pop", data_out, exp4[i]);
         step;
      end
      data_ready_in = 1'b0;
      check_val("t4_empty", fifo_level_out, 0);

      // ---------------- T5 timeout, then flag already high on entry
      single_shot_in = 1'b1;
      step;
      single_shot_in = 1'b0;
      step(4099);
      check_val("t5_tmo_early", timeout_out, 0);
      step;
      check_val("t5_tmo",   timeout_out, 1);
      check_val("t5_nopush", fifo_level_out, 0);
      step;
      check_val("t5_idle", busy_out, 0);
      clear_flags_in = 1'b1;
      step;
      clear_flags_in = 1'b0;
      check_val("t5_clear", timeout_out, 0);
      d_res = 16'h1234;
      d_fin = 1'b1;
      step(3);
      single_shot_in = 1'b1;
      step;
      single_shot_in = 1'b0;
      step(15);
      check_val("t5_held_level", fifo_level_out, 0);
      check_val("t5_held_busy",  busy_out, 1);
      d_fin = 1'b0;
      step(3);
      d_res = 16'h5A5A;
      d_fin = 1'b1;
      step(3);
      check_val("t5_cap_valid", data_valid_out, 1);
      check_val("t5_cap_data",  data_out, 16'h5A5A);
      d_fin = 1'b0;
      data_ready_in = 1'b1;
      step;
      data_ready_in = 1'b0;
      step(2);

      // ---------------- T6 asynchronous reset mid-run
      adc_auto  = 1'b1;
      adc_delay = 5;
      adc_base  = 16'h0100 - 16'(n_conv);
      enable_in = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 300; c++) begin
         step;
         if (fifo_level_out == 3'd3 && start_conversion_out) begin
            found = 1'b1;
            break;
         end
      end
      check_val("t6_setup", found, 1);
      #1 rst = 1'b1;
      #1;
      check_val("t6_start", start_conversion_out, 0);
      check_val("t6_valid", data_valid_out, 0);
      check_val("t6_data",  data_out, 0);
      check_val("t6_level", fifo_level_out, 0);
      check_val("t6_busy",  busy_out, 0);
      adc_auto  = 1'b0;
      enable_in = 1'b0;
      step(2);
      rst = 1'b0;
      step(3);
      check_val("t6_post_busy",  busy_out, 0);
      check_val("t6_post_level", fifo_level_out, 0);
      check_val("t6_post_start", start_conversion_out, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
